// File: rtl/pipe_pkg.sv
// Shared types and bundle widths for inter-stage pipeline registers.
// Optional stall counter in pipe_stage_reg is enabled by PIPE_STALL_CNT_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int IF_ID_W   = 64;
  localparam int ID_EXE_W  = 96;
  localparam int EXE_MEM_W = 80;
  localparam int MEM_WB_W  = 72;
  localparam int CTRL_DEF_W = 16;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_LSB   = 4;
  localparam int CTRL_ALU_W     = 4;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main + skid storage with EMPTY/FULL/SKID FSM.
// in_ready is a flop, so upstream never sees a path from out_ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 112
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bus
);

  pipe_state_e state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         pop;

  assign out_valid = (state != EMPTY);
  assign out_bus   = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state  <= FULL;
            main_q <= in_bus;
          end
        end
        FULL: begin
          unique case (1'b1)
            accept & pop: main_q <= in_bus;
            accept & !pop: begin
              state    <= SKID;
              skid_q   <= in_bus;
              in_ready <= 1'b0;
            end
            !accept & pop: state <= EMPTY;
            default: ;
          endcase
        end
        SKID: begin
          if (pop) begin
            state    <= FULL;
            main_q   <= skid_q;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with skid buffer and flush.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EXE_W,
  parameter int CTRL_W = CTRL_DEF_W
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int W = DATA_W + CTRL_W;

  logic [W-1:0] out_bus;

  pipe_skid_buf #(
    .W(W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bus   ({in_ctrl, in_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bus  (out_bus)
  );

  assign out_data = out_bus[DATA_W-1:0];
  // bubbles must never carry write enables downstream
  assign out_ctrl = out_bus[W-1:DATA_W] & {CTRL_W{out_valid}};

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register that generalises the fixed ID/EXE latch. Carries a DATA_W-bit datapath bundle and a CTRL_W-bit control bundle with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/hazard bubbles. Instantiated between any two CPU stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

Parameters:
DATA_W, 96, width of datapath bundle (pc+4, operands, immediates, ...)
CTRL_W, 16, width of control bundle (RegWrite, MemWrite, ALUctrl, ...); forced to 0 whenever out_valid=0
CNT_W, 16, stall counter width (used only with PIPE_STALL_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream stage presents a valid bundle
in_ready  out  1  this stage can accept; registered, never depends combinationally on out_ready
in_data  in  DATA_W  upstream datapath bundle
in_ctrl  in  CTRL_W  upstream control bundle
flush  in  1  synchronous kill of all held entries (branch taken, exception)
out_valid  out  1  downstream bundle valid
out_ready  in  1  downstream stage accepts (0 = stall)
out_data  out  DATA_W  registered datapath bundle
out_ctrl  out  CTRL_W  registered control bundle; 0 when out_valid=0 (bubble)
stall_cnt  out  CNT_W  back-pressure cycle count (only with PIPE_STALL_CNT_EN)

Behaviour:
- Reset (rst=0, async): state EMPTY; out_valid=0, out_data=0, out_ctrl=0, in_ready=1, internal skid regs=0, stall_cnt=0.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (no entry), FULL (main reg valid), SKID (main + skid valid).
- EMPTY: accept -> FULL, main<=in.
- FULL: accept&pop -> FULL, main<=in; accept&!pop -> SKID, skid<=in; !accept&pop -> EMPTY; else hold.
- SKID: in_ready=0; pop -> FULL, main<=skid; else hold.
- in_ready = (next state != SKID), registered.
- Latency: accept at edge N -> out_valid=1 after edge N (visible in cycle N+1). Throughput 1 bundle/cycle when out_ready held 1.
- Ordering strictly FIFO; no bundle dropped or duplicated except by flush.
- flush=1 at edge: next state EMPTY, out_valid=0, in_ready=1; flush dominates a same-cycle accept and pop (incoming bundle discarded).
- out_ctrl masked to 0 whenever out_valid=0 so bubbles never write regfile/memory; out_data holds last value when invalid (don't-care).
- Reset mid-operation: all entries discarded immediately, no partial bundle emitted.
- in_data/in_ctrl sampled only on accept; values while in_valid=0 ignored.

Optional Feature:
PIPE_STALL_CNT_EN: defined -> stall_cnt port present; increments on every cycle with out_valid=1 & out_ready=0, saturates at 2^CNT_W-1, cleared only by reset (not flush). Undefined -> port and counter absent, no logic.

Decomposition:
- Shared package pipe_pkg: state enum (EMPTY, FULL, SKID), default widths for each stage bundle (IF_ID_W, ID_EXE_W, EXE_MEM_W, MEM_WB_W) and control-field bit offsets.
- One natural sub-module: pipe_skid_buf (main+skid storage and state machine); pipe_stage_reg wraps it with ctrl masking, flush and counter.

Test Plan:
- Reset: rst=0 with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1; release rst, stream 0x1,0x2,0x3 with out_ready=1 -> out sequence 0x1,0x2,0x3 one cycle after each accept, no gaps.
- Back-pressure: accept A=0xA, B=0xB with out_ready=0 -> state SKID, in_ready=0 from next cycle, out_data=0xA held; raise out_ready -> 0xA then 0xB, in_ready returns 1 after first pop.
- Flush: state SKID holding 0xA/0xB, flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0xA/0xB/0xC never appear.
- Bubble masking: in_valid=0 for 3 cycles with in_ctrl=0xFFFF -> out_ctrl=0 throughout.
- Async reset mid-stream: drop rst between edges while FULL -> out_valid falls without a clock edge; no stale bundle after release.
- PIPE_STALL_CNT_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush -> stall_cnt stays 15.
